// File: rtl/regfile_dump_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_if
// Purpose  : valid/ready stream carrying one dumped register word and its index.
// Revision : 1.0  initial release
// ============================================================================
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_last;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_addr,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_addr,
    input  dump_last,
    output dump_ready
  );
endinterface
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Purpose  : walks a register-file index range through one asynchronous read
//            port and streams each word out over a valid/ready interface.
// Revision : 1.0  initial release
// ============================================================================
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  regfile_dump_if.master    dump,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              error_q, error_d;

  logic              w_at_end;
  logic              w_handshake;

  assign w_at_end    = (ptr_q == end_q);
  assign w_handshake = valid_q && dump.dump_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            ptr_d   = first_reg;
            end_d   = last_reg;
            state_d = S_LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        // The word is a snapshot of the read port at this edge; later writes never reach it.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          data_d  = rf_read_data;
          addr_d  = ptr_q;
          last_d  = w_at_end;
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        // Abort wins over a same-cycle handshake, so that word is treated as unsent.
        if (abort) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (w_handshake) begin
          valid_d = 1'b0;
          if (w_at_end) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = S_LOAD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rf_read_reg     = (state_q == S_LOAD) ? ptr_q : '0;
  assign busy            = (state_q == S_LOAD) || (state_q == S_SEND);
  assign done            = (state_q == S_DONE);
  assign error           = error_q;

  assign dump.dump_valid = valid_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_addr  = addr_q;
  assign dump.dump_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump
// Purpose  : self-checking bench for regfile_dump against a range/queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_dump;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] rf [32];

  int n_pass  = 0;
  int n_total = 0;

  regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) dif ();

  regfile_dump #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .first_reg    (first_reg),
    .last_reg     (last_reg),
    .rf_read_reg  (rf_read_reg),
    .rf_read_data (rf_read_data),
    .dump         (dif),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  assign rf_read_data = rf[rf_read_reg];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int first;
    int last;
    int rdy_pct;
    int abort_at;
    bit exp_err;
    int exp_words;
    bit exp_done;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rf();
    rf[0] = 32'h0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
  endtask

  // Model: a dump of first..last yields words first+i, rf[first+i], last flag on the final index.
  task automatic run_dump(input int first, input int last, input int rdy_pct, input int abort_at,
                          input bit exp_err, input int exp_words, input bit exp_done);
    int idx;
    int cyc;
    bit fin;
    bit aborting;
    bit seen_done;
    idx = 0; cyc = 0; fin = 0; aborting = 0; seen_done = 0;
    start = 1'b1;
    first_reg = 5'(first);
    last_reg  = 5'(last);
    step();
    start = 1'b0;
    if (exp_err) begin
      chk("err_pulse", error, 1);
      chk("err_busy", busy, 0);
      chk("err_valid", dif.dump_valid, 0);
      step();
      chk("err_clear", error, 0);
      chk("err_novalid", dif.dump_valid, 0);
      chk("err_nobusy", busy, 0);
      return;
    end
    chk("start_busy", busy, 1);
    chk("start_noerr", error, 0);
    chk("load_addr", rf_read_reg, first);
    while (!fin && cyc < 400) begin
      if (aborting) begin
        chk("abort_valid", dif.dump_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        abort = 1'b0;
        start = 1'b0;
        fin = 1;
      end else if (done) begin
        chk("done_busy", busy, 0);
        chk("done_valid", dif.dump_valid, 0);
        seen_done = 1;
        fin = 1;
        // start and abort in the DONE cycle must both be ignored
        start = $urandom_range(1);
        abort = $urandom_range(1);
        first_reg = 5'($urandom);
        last_reg  = 5'($urandom);
      end else begin
        chk("busy_mid", busy, 1);
        chk("noerr_mid", error, 0);
        if (dif.dump_valid) begin
          chk("word_in_range", (first + idx <= last), 1);
          chk("word_addr", dif.dump_addr, first + idx);
          chk("word_data", dif.dump_data, rf[(first + idx) % 32]);
          chk("word_last", dif.dump_last, (first + idx == last));
          dif.dump_ready = ($urandom_range(99) < rdy_pct);
          if (idx == abort_at) begin
            abort = 1'b1;
            aborting = 1;
          end else if (dif.dump_ready) begin
            idx++;
          end
        end else begin
          dif.dump_ready = $urandom_range(1);
        end
        if (!aborting && $urandom_range(3) == 0) begin
          start = 1'b1;
          first_reg = 5'($urandom);
          last_reg  = 5'($urandom);
        end else begin
          start = 1'b0;
        end
      end
      step();
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    dif.dump_ready = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_err", error, 0);
    chk("idle_valid", dif.dump_valid, 0);
    chk("word_count", idx, exp_words);
    chk("done_seen", seen_done, exp_done);
  endtask

  initial begin
    int f, l, ab, nw;
    bit er;
    vecs[0] = '{1, 3, 100, -1, 1'b0, 3, 1'b1};
    vecs[1] = '{5, 5, 50, -1, 1'b0, 1, 1'b1};
    vecs[2] = '{7, 2, 100, -1, 1'b1, 0, 1'b0};
    vecs[3] = '{0, 31, 60, -1, 1'b0, 32, 1'b1};
    vecs[4] = '{0, 9, 70, 2, 1'b0, 2, 1'b0};
    vecs[5] = '{0, 9, 100, -1, 1'b0, 10, 1'b1};
    vecs[6] = '{31, 31, 30, -1, 1'b0, 1, 1'b1};
    vecs[7] = '{0, 0, 100, -1, 1'b0, 1, 1'b1};
    vecs[8] = '{31, 0, 100, -1, 1'b1, 0, 1'b0};
    vecs[9] = '{10, 20, 50, 0, 1'b0, 0, 1'b0};

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    first_reg = '0; last_reg = '0; dif.dump_ready = 1'b0;
    fill_rf();
    repeat (3) step();
    chk("rst_valid", dif.dump_valid, 0);
    chk("rst_data", dif.dump_data, 0);
    chk("rst_addr", dif.dump_addr, 0);
    chk("rst_last", dif.dump_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_rdaddr", rf_read_reg, 0);
    reset = 1'b1;
    step();

    // Latency: ready high, three words every other cycle, done right after the last.
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
    dif.dump_ready = 1'b1;
    start = 1'b1; first_reg = 5'd1; last_reg = 5'd3;
    step();
    start = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      chk("lat_valid", dif.dump_valid, (c % 2 == 1) && (c < 6));
      if ((c % 2 == 1) && (c < 6)) begin
        chk("lat_addr", dif.dump_addr, (c + 1) / 2);
        chk("lat_data", dif.dump_data, 32'h11 * ((c + 1) / 2));
        chk("lat_last", dif.dump_last, (c == 5));
      end
      chk("lat_done", done, (c == 6));
      step();
    end
    dif.dump_ready = 1'b0;

    // Stall: held word stays stable and ignores a later register-file write.
    rf[5] = 32'hDEADBEEF;
    start = 1'b1; first_reg = 5'd5; last_reg = 5'd5;
    step();
    start = 1'b0;
    step();
    rf[5] = 32'h12345678;
    for (int c = 0; c < 4; c++) begin
      chk("stall_valid", dif.dump_valid, 1);
      chk("stall_data", dif.dump_data, 32'hDEADBEEF);
      chk("stall_addr", dif.dump_addr, 5);
      chk("stall_last", dif.dump_last, 1);
      if (c == 3) dif.dump_ready = 1'b1;
      step();
    end
    dif.dump_ready = 1'b0;
    chk("stall_done", done, 1);
    chk("stall_valid_off", dif.dump_valid, 0);
    step();
    chk("stall_done_off", done, 0);

    // Table vectors.
    for (int i = 0; i < 10; i++) begin
      fill_rf();
      run_dump(vecs[i].first, vecs[i].last, vecs[i].rdy_pct, vecs[i].abort_at,
               vecs[i].exp_err, vecs[i].exp_words, vecs[i].exp_done);
      step();
    end

    // Randomized ranges, expectations derived from range arithmetic.
    for (int i = 0; i < 16; i++) begin
      fill_rf();
      f  = $urandom_range(31);
      l  = $urandom_range(31);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(31)) : -1;
      er = (f > l);
      nw = er ? 0 : ((ab >= 0 && ab <= l - f) ? ab : l - f + 1);
      run_dump(f, l, $urandom_range(20, 100), ab, er, nw,
               !er && !(ab >= 0 && ab <= l - f));
    end

    // Reset asserted while a word is held: outputs clear immediately.
    fill_rf();
    start = 1'b1; first_reg = 5'd3; last_reg = 5'd8;
    step();
    start = 1'b0;
    step();
    chk("pre_rst_valid", dif.dump_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", dif.dump_valid, 0);
    chk("mid_rst_data", dif.dump_data, 0);
    chk("mid_rst_addr", dif.dump_addr, 0);
    chk("mid_rst_last", dif.dump_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", dif.dump_valid, 0);
    run_dump(0, 4, 80, -1, 1'b0, 5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
